// File: rtl/ex_advint_ctrl.sv
// Sequencing controller for the advanced integer unit (MUL/MULU/DIV/DIVU).
// Holds operands stable for a fixed op-dependent cycle count, then captures and hands off both result halves.
module ex_advint_ctrl #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 16,
   parameter int TAG_W      = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [2:0]       issue_unit,
   input  logic [1:0]       issue_op,
   input  logic [63:0]      issue_in1,
   input  logic [63:0]      issue_in2,
   input  logic [TAG_W-1:0] issue_rd,
   input  logic [TAG_W-1:0] issue_rd2,
   output logic             au_enable,
   output logic [2:0]       au_unit,
   output logic [1:0]       au_op,
   output logic [63:0]      au_in1,
   output logic [63:0]      au_in2,
   input  logic [63:0]      au_out,
   input  logic [63:0]      au_out2,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [63:0]      res_data,
   output logic [63:0]      res_data2,
   output logic [TAG_W-1:0] res_rd,
   output logic [TAG_W-1:0] res_rd2,
   output logic             res_dbz,
   output logic             busy
);

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
   localparam logic [2:0]  UNIT_ID  = 3'h4;
   localparam logic [63:0] INT_MIN  = 64'h8000_0000_0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic [63:0]        in1_q, in1_d;
   logic [63:0]        in2_q, in2_d;
   logic [TAG_W-1:0]   rd_q, rd_d;
   logic [TAG_W-1:0]   rd2_q, rd2_d;
   logic [63:0]        data_q, data_d;
   logic [63:0]        data2_q, data2_d;
   logic               dbz_q, dbz_d;

   logic accept;
   logic is_div;
   logic div_by_zero;
   logic div_overflow;

   assign issue_ready  = (state_q == ST_IDLE) & ~flush;
   assign accept       = issue_valid & issue_ready & (issue_unit == UNIT_ID);
   assign is_div       = issue_op[1];
   assign div_by_zero  = is_div & (issue_in2 == 64'd0);
   // Only signed DIV can overflow: INT_MIN / -1 has no representable quotient.
   assign div_overflow = (issue_op == 2'd2) & (issue_in1 == INT_MIN) & (issue_in2 == '1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      in1_d   = in1_q;
      in2_d   = in2_q;
      rd_d    = rd_q;
      rd2_d   = rd2_q;
      data_d  = data_q;
      data2_d = data2_q;
      dbz_d   = dbz_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d  = issue_op;
               in1_d = issue_in1;
               in2_d = issue_in2;
               rd_d  = issue_rd;
               rd2_d = issue_rd2;
               cnt_d = is_div ? DIV_LOAD : MUL_LOAD;
               if (div_by_zero) begin
                  data_d  = '1;
                  data2_d = issue_in1;
                  dbz_d   = 1'b1;
                  state_d = ST_DONE;
               end else if (div_overflow) begin
                  data_d  = INT_MIN;
                  data2_d = '0;
                  dbz_d   = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (cnt_q == '0) begin
               data_d  = au_out;
               data2_d = au_out2;
               dbz_d   = 1'b0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (res_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Flush wins over both a new issue and a writeback handshake.
      if (flush) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         in1_q   <= '0;
         in2_q   <= '0;
         rd_q    <= '0;
         rd2_q   <= '0;
         data_q  <= '0;
         data2_q <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         rd_q    <= rd_d;
         rd2_q   <= rd2_d;
         data_q  <= data_d;
         data2_q <= data2_d;
         dbz_q   <= dbz_d;
      end
   end

   assign au_enable = (state_q == ST_RUN);
   assign au_unit   = UNIT_ID;
   assign au_op     = op_q;
   assign au_in1    = in1_q;
   assign au_in2    = in2_q;
   assign res_valid = (state_q == ST_DONE);
   assign res_data  = data_q;
   assign res_data2 = data2_q;
   assign res_rd    = rd_q;
   assign res_rd2   = rd2_q;
   assign res_dbz   = dbz_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ex_advint_ctrl.sv
// Self-checking bench for ex_advint_ctrl: the bench plays the arithmetic unit and writeback,
// and a scoreboard queue holds the expected {dbz, lo, hi, rd, rd2} of every accepted operation.
module tb_ex_advint_ctrl;

   localparam int TAG_W      = 6;
   localparam int MUL_CYCLES = 4;
   localparam int DIV_CYCLES = 16;
   localparam int EXP_W      = 1 + 64 + 64 + 2 * TAG_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             issue_valid = 1'b0;
   logic             issue_ready;
   logic [2:0]       issue_unit = 3'h4;
   logic [1:0]       issue_op = '0;
   logic [63:0]      issue_in1 = '0;
   logic [63:0]      issue_in2 = '0;
   logic [TAG_W-1:0] issue_rd = '0;
   logic [TAG_W-1:0] issue_rd2 = '0;
   logic             au_enable;
   logic [2:0]       au_unit;
   logic [1:0]       au_op;
   logic [63:0]      au_in1;
   logic [63:0]      au_in2;
   logic [63:0]      au_out;
   logic [63:0]      au_out2;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [63:0]      res_data;
   logic [63:0]      res_data2;
   logic [TAG_W-1:0] res_rd;
   logic [TAG_W-1:0] res_rd2;
   logic             res_dbz;
   logic             busy;

   int n_tests = 0;
   int n_fails = 0;
   logic [EXP_W-1:0] exp_q[$];

   ex_advint_ctrl #(
      .MUL_CYCLES(MUL_CYCLES),
      .DIV_CYCLES(DIV_CYCLES),
      .TAG_W(TAG_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_unit(issue_unit),
      .issue_op(issue_op), .issue_in1(issue_in1), .issue_in2(issue_in2),
      .issue_rd(issue_rd), .issue_rd2(issue_rd2),
      .au_enable(au_enable), .au_unit(au_unit), .au_op(au_op),
      .au_in1(au_in1), .au_in2(au_in2), .au_out(au_out), .au_out2(au_out2),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_data2(res_data2), .res_rd(res_rd), .res_rd2(res_rd2),
      .res_dbz(res_dbz), .busy(busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- arithmetic unit stand-in ----------------
   // Results are only meaningful while enabled, so a capture at the wrong time shows up as garbage.
   always_comb begin
      logic [127:0] p;
      au_out  = 64'hBAD0_BAD0_BAD0_BAD0;
      au_out2 = 64'hBAD1_BAD1_BAD1_BAD1;
      p       = '0;
      if (au_enable) begin
         case (au_op)
            2'd0: begin
               p = {{64{au_in1[63]}}, au_in1} * {{64{au_in2[63]}}, au_in2};
               au_out = p[63:0]; au_out2 = p[127:64];
            end
            2'd1: begin
               p = {64'd0, au_in1} * {64'd0, au_in2};
               au_out = p[63:0]; au_out2 = p[127:64];
            end
            2'd2: if (au_in2 != 0) begin
               au_out  = $signed(au_in1) / $signed(au_in2);
               au_out2 = $signed(au_in1) % $signed(au_in2);
            end
            default: if (au_in2 != 0) begin
               au_out  = au_in1 / au_in2;
               au_out2 = au_in1 % au_in2;
            end
         endcase
      end
   end

   // ---------------- reference model: {dbz, lo, hi} ----------------
   function automatic logic [128:0] model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      logic [63:0]  q;
      logic [63:0]  r;
      if (op == 2'd0) begin
         p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
         return {1'b0, p[63:0], p[127:64]};
      end else if (op == 2'd1) begin
         p = {64'd0, a} * {64'd0, b};
         return {1'b0, p[63:0], p[127:64]};
      end else if (b == 64'd0) begin
         return {1'b1, {64{1'b1}}, a};
      end else if (op == 2'd2 && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) begin
         return {1'b0, 64'h8000_0000_0000_0000, 64'd0};
      end else if (op == 2'd2) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
         return {1'b0, q, r};
      end
      q = a / b;
      r = a % b;
      return {1'b0, q, r};
   endfunction

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic wait_issue_ready(input string tag);
      int k;
      k = 0;
      while (!issue_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_issue_ready_wait"}, 128'(issue_ready), 128'(1'b1));
   endtask

   // Present one operation for exactly one accept edge; returns at the negedge after it.
   task automatic issue(input logic [2:0] unit, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [TAG_W-1:0] rd, input logic [TAG_W-1:0] rd2);
      issue_valid = 1'b1;
      issue_unit  = unit;
      issue_op    = op;
      issue_in1   = a;
      issue_in2   = b;
      issue_rd    = rd;
      issue_rd2   = rd2;
      @(negedge clk);
      issue_valid = 1'b0;
      issue_in1   = $urandom();
      issue_in2   = $urandom();
   endtask

   // Full operation: push expectation, track enable/latency, compare, then hold backpressure.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [TAG_W-1:0] rd,
                         input logic [TAG_W-1:0] rd2, input int hold);
      logic [128:0]     m;
      logic [EXP_W-1:0] e;
      logic [EXP_W-1:0] snap;
      int               n;
      int               k;
      int               en;
      logic             special;
      logic [63:0]      a0;
      logic [63:0]      b0;
      logic [1:0]       op0;

      wait_issue_ready(tag);
      m       = model(op, a, b);
      special = op[1] && (b == 64'd0 || (op == 2'd2 && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}));
      n       = op[1] ? DIV_CYCLES : MUL_CYCLES;
      exp_q.push_back({m, rd, rd2});
      issue(3'h4, op, a, b, rd, rd2);

      // Negedge k follows edge E(k-1); res_valid registered on edge E(lat) is seen at k = lat+1.
      k  = 1;
      en = 0;
      a0 = au_in1; b0 = au_in2; op0 = au_op;
      while (k < 400) begin
         en += au_enable;
         if (au_enable && (au_in1 != a0 || au_in2 != b0 || au_op != op0)) begin
            check({tag, "_operand_stable"}, {au_op, au_in1}, {op0, a0});
         end
         if (res_valid) break;
         @(negedge clk);
         k++;
      end
      check({tag, "_res_valid_seen"}, 128'(res_valid), 128'(1'b1));
      check({tag, "_latency"}, 128'(k - 1), 128'(special ? 0 : n));
      check({tag, "_enable_cycles"}, 128'(en), 128'(special ? 0 : n));
      if (!special) check({tag, "_operands"}, {au_op, au_in1}, {op, a});

      if (exp_q.size() == 0) begin
         check({tag, "_scoreboard_nonempty"}, 128'(0), 128'(1));
      end else begin
         e = exp_q.pop_front();
         check({tag, "_res_data"},  128'(res_data),  128'(e[EXP_W-2 -: 64]));
         check({tag, "_res_data2"}, 128'(res_data2), 128'(e[EXP_W-66 -: 64]));
         check({tag, "_res_tags"},  128'({res_rd, res_rd2}), 128'(e[2*TAG_W-1:0]));
         check({tag, "_res_dbz"},   128'(res_dbz),   128'(e[EXP_W-1]));
      end

      snap = {res_dbz, res_data, res_data2, res_rd, res_rd2};
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, 128'({res_valid, issue_ready}), 128'(2'b10));
         check({tag, "_hold_data"}, 128'({res_dbz, res_data, res_data2} ^ snap[EXP_W-1:2*TAG_W]), 128'(0));
         check({tag, "_hold_tags"}, 128'({res_rd, res_rd2}), 128'(snap[2*TAG_W-1:0]));
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check({tag, "_idle_after_ready"}, 128'({busy, res_valid, issue_ready}), 128'(3'b001));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int seen;
      logic [1:0]  rop;
      logic [63:0] ra;
      logic [63:0] rb;

      repeat (2) @(negedge clk);
      check("reset_ctrl", 128'({busy, res_valid, res_dbz, au_enable, issue_ready}), 128'(5'b00001));
      check("reset_au", 128'({au_unit, au_op, au_in1}), 128'({3'h4, 2'd0, 64'd0}));
      check("reset_au_in2", 128'(au_in2), 128'(0));
      check("reset_res", 128'({res_data, res_data2}), 128'(0));
      check("reset_tags", 128'({res_rd, res_rd2}), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);

      run_op("mul",   2'd0, -64'sd3, 64'd5, 6'd11, 6'd12, 0);
      run_op("divu",  2'd3, 64'd100, 64'd7, 6'd21, 6'd22, 1);
      run_op("dbz",   2'd2, 64'd42,  64'd0, 6'd31, 6'd32, 0);
      run_op("ovf",   2'd2, 64'h8000_0000_0000_0000, {64{1'b1}}, 6'd33, 6'd34, 0);
      run_op("bp",    2'd1, {64{1'b1}}, {64{1'b1}}, 6'd41, 6'd42, 5);
      run_op("divs",  2'd2, -64'sd100, 64'd7, 6'd43, 6'd44, 2);
      run_op("divuz", 2'd3, 64'd9,   64'd0, 6'd45, 6'd46, 3);

      // Flush on cycle 2 of a DIV run: back to IDLE, no result ever.
      wait_issue_ready("flush_run");
      issue(3'h4, 2'd2, 64'd1000, 64'd3, 6'd1, 6'd2);
      @(negedge clk);
      flush = 1'b1;
      check("flush_blocks_issue", 128'(issue_ready), 128'(0));
      @(negedge clk);
      flush = 1'b0;
      check("flush_run_idle", 128'({busy, au_enable, res_valid}), 128'(0));
      seen = 0;
      for (int i = 0; i < DIV_CYCLES + 4; i++) begin
         @(negedge clk);
         seen += res_valid;
      end
      check("flush_run_no_result", 128'(seen), 128'(0));

      // Flush while a result is waiting discards it and beats res_ready.
      issue(3'h4, 2'd3, 64'd5, 64'd0, 6'd3, 6'd4);
      check("flush_done_pre", 128'(res_valid), 128'(1));
      flush     = 1'b1;
      res_ready = 1'b1;
      @(negedge clk);
      flush     = 1'b0;
      res_ready = 1'b0;
      check("flush_done_dropped", 128'({busy, res_valid}), 128'(0));

      // Wrong unit select is never accepted.
      issue_valid = 1'b1;
      issue_unit  = 3'h2;
      issue_op    = 2'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("unit_filter", 128'({busy, au_enable, res_valid}), 128'(0));
      end
      issue_valid = 1'b0;
      issue_unit  = 3'h4;

      // Asynchronous reset mid-RUN.
      issue(3'h4, 2'd0, 64'd7, 64'd9, 6'd5, 6'd6);
      check("pre_reset_running", 128'(au_enable), 128'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_ctrl", 128'({busy, au_enable, res_valid, res_dbz, issue_ready}), 128'(5'b00001));
      check("rst_au", 128'({au_op, au_in1}), 128'(0));
      check("rst_au_in2", 128'(au_in2), 128'(0));
      check("rst_tags", 128'({res_rd, res_rd2, au_unit}), 128'(3'h4));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Randomised operations.
      for (int t = 0; t < 10; t++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = ($urandom_range(0, 1) == 1) ? {$urandom(), $urandom()} : 64'($urandom_range(0, 1000));
         rb  = ($urandom_range(0, 5) == 0) ? 64'd0 : {$urandom(), $urandom()};
         if ($urandom_range(0, 1) == 1) rb = 64'($urandom_range(1, 50));
         run_op("rand", rop, ra, rb, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                $urandom_range(0, 3));
      end

      check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

endmodule
